graph_edge_fetch: RTL and testbench

GRAPH_EDGE_FETCH -- requirements
Module: graph_edge_fetch

---
 rtl/graph_pkg.sv | 12 +
 rtl/word_fifo.sv | 40 ++++
 rtl/graph_edge_fetch.sv | 107 ++++++++++
 tb/tb_graph_edge_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/graph_pkg.sv
// graph_pkg: edge record field layout, count width and fetch FSM state encoding
package graph_pkg;
    localparam int EDGE_W  = 64;
    localparam int CNT_W   = 14;
    localparam int SRC_MSB = 63;
    localparam int SRC_W   = 13;
    localparam int DST_MSB = 50;
    localparam int DST_W   = 13;
    localparam int WGT_MSB = 37;
    localparam int WGT_W   = 16;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_DRAIN} state_e;
endpackage

// File: rtl/word_fifo.sv
// word_fifo: registered FIFO that accepts up to two words per cycle and pops one.
// Ports: clock/reset (sync, active-high); push_a/din_a first word, push_b/din_b second
// word (only used together with push_a); pop removes head; head is the oldest word;
// count is the current occupancy. Pushing beyond DEPTH is prevented by the writer.
module word_fifo #(
    parameter int W     = 128,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_a,
    input  logic                     push_b,
    input  logic [W-1:0]             din_a,
    input  logic [W-1:0]             din_b,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q;
    always_ff @(posedge clock) begin
        if (push_a) mem_q[wr_q] <= din_a;
        if (push_b) mem_q[wr_q + 1'b1] <= din_b;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + PW'(push_a) + PW'(push_b);
            rd_q  <= rd_q + PW'(pop);
            cnt_q <= cnt_q + (PW+1)'(push_a) + (PW+1)'(push_b) - (PW+1)'(pop);
        end
    end
    assign head  = mem_q[rd_q];
    assign count = cnt_q;
endmodule

// File: rtl/graph_edge_fetch.sv
// graph_edge_fetch: streams packed 64-bit edge records out of a dual-read-port graph memory.
// Ports: clock/reset (sync, active-high); start/base_addr/edge_count launch a job;
// ReadAddress1/2 + ReadBus1/2 are two read ports with one-cycle latency; edge_valid/
// edge_ready handshake carries edge_src/dst/weight/last; busy spans a job, done pulses at its end.
module graph_edge_fetch
    import graph_pkg::*;
#(
    parameter int WORD_W     = 128,
    parameter int ADDR_W     = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  edge_count,
    output logic [ADDR_W-1:0] ReadAddress1,
    output logic [ADDR_W-1:0] ReadAddress2,
    input  logic [WORD_W-1:0] ReadBus1,
    input  logic [WORD_W-1:0] ReadBus2,
    output logic              edge_valid,
    input  logic              edge_ready,
    output logic [SRC_W-1:0]  edge_src,
    output logic [DST_W-1:0]  edge_dst,
    output logic [WGT_W-1:0]  edge_weight,
    output logic              edge_last,
    output logic              busy,
    output logic              done
);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int UW  = FCW + 1;
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] next_q, ra1_q, ra2_q;
    logic [CNT_W-1:0]  words_q, edges_q;
    logic [1:0]        cap_q;
    logic              half_q, done_q;
    logic [FCW-1:0]    fcnt;
    logic [WORD_W-1:0] head;
    logic [UW-1:0]     used;
    logic              accept, two, issue, xfer, last, pop;
    assign accept = start && !busy;
    // Words already buffered plus words whose read data lands next edge.
    assign used  = UW'(fcnt) + UW'(cap_q[0]) + UW'(cap_q[1]);
    assign two   = words_q > CNT_W'(1);
    assign issue = state_q == ST_FETCH && words_q != '0 && used + UW'(2) <= UW'(FIFO_DEPTH);
    assign xfer  = edge_valid && edge_ready;
    assign last  = xfer && edges_q == CNT_W'(1);
    // Head word retires after its high half, or after its low half when it is the final edge.
    assign pop   = xfer && (half_q || edges_q == CNT_W'(1));
    word_fifo #(.W(WORD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock  (clock),
        .reset  (reset),
        .push_a (cap_q[0]),
        .push_b (cap_q[1]),
        .din_a  (ReadBus1),
        .din_b  (ReadBus2),
        .pop    (pop),
        .head   (head),
        .count  (fcnt)
    );
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = (state_q == ST_IDLE  && accept && edge_count != '0)  ? ST_FETCH :
                  (state_q == ST_FETCH && issue && words_q <= CNT_W'(2)) ? ST_DRAIN :
                  (state_q == ST_DRAIN && last)                         ? ST_IDLE  : state_q;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            next_q  <= '0;
            ra1_q   <= '0;
            ra2_q   <= '0;
            words_q <= '0;
            edges_q <= '0;
            cap_q   <= '0;
            half_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (accept) begin
                next_q  <= base_addr;
                words_q <= {1'b0, edge_count[CNT_W-1:1]} + CNT_W'(edge_count[0]);
            end else if (issue) begin
                ra1_q   <= next_q;
                ra2_q   <= next_q + 1'b1;
                next_q  <= next_q + (two ? ADDR_W'(2) : ADDR_W'(1));
                words_q <= words_q - (two ? CNT_W'(2) : CNT_W'(1));
            end
            cap_q   <= issue ? {two, 1'b1} : 2'b00;
            edges_q <= accept ? edge_count : xfer ? edges_q - 1'b1 : edges_q;
            half_q  <= pop ? 1'b0 : xfer ? 1'b1 : half_q;
            done_q  <= last || (accept && edge_count == '0);
        end
    end
    always_comb begin
        edge_valid  = fcnt != '0;
        busy        = state_q != ST_IDLE || done_q;
        edge_last   = edge_valid && edges_q == CNT_W'(1);
        edge_src    = edge_valid ? head[int'(half_q) * EDGE_W + SRC_MSB -: SRC_W] : '0;
        edge_dst    = edge_valid ? head[int'(half_q) * EDGE_W + DST_MSB -: DST_W] : '0;
        edge_weight = edge_valid ? head[int'(half_q) * EDGE_W + WGT_MSB -: WGT_W] : '0;
    end
    assign ReadAddress1 = ra1_q;
    assign ReadAddress2 = ra2_q;
    assign done         = done_q;
endmodule

// File: tb/tb_graph_edge_fetch.sv
// tb_graph_edge_fetch: random-memory, random-ready checks of graph_edge_fetch against an edge-list model
module tb_graph_edge_fetch;
    logic         clock = 1'b0, reset = 1'b1, start = 1'b0, edge_ready = 1'b0;
    logic [12:0]  base_addr = '0;
    logic [13:0]  edge_count = '0;
    logic [12:0]  ReadAddress1, ReadAddress2, edge_src, edge_dst;
    logic [127:0] ReadBus1, ReadBus2;
    logic [15:0]  edge_weight;
    logic         edge_valid, edge_last, busy, done;
    logic [127:0] mem [8192];

    typedef struct {
        logic [12:0] s;
        logic [12:0] d;
        logic [15:0] w;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [12:0] ra1_log[$], ra2_log[$];
    logic [12:0] ra1_prev = '0;
    int          n_cmp = 0, n_bad = 0, done_cnt = 0, valid_cnt = 0, xfer_cnt = 0;
    logic        hold_v = 1'b0, hl;
    logic [12:0] hs, hd;
    logic [15:0] hw;

    graph_edge_fetch dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .edge_count(edge_count),
        .ReadAddress1(ReadAddress1), .ReadAddress2(ReadAddress2), .ReadBus1(ReadBus1), .ReadBus2(ReadBus2),
        .edge_valid(edge_valid), .edge_ready(edge_ready), .edge_src(edge_src), .edge_dst(edge_dst),
        .edge_weight(edge_weight), .edge_last(edge_last), .busy(busy), .done(done)
    );

    assign ReadBus1 = mem[ReadAddress1];
    assign ReadBus2 = mem[ReadAddress2];
    always #5 clock = ~clock;

    task automatic check(input string tag, input longint got, input longint want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic rdy(input int c, input int md, input int stl);
        return md == 0 ? 1'b1 : md == 1 ? 1'($urandom_range(0, 1)) : (c > stl);
    endfunction

    // Monitor: transfers and hold-stability sampled mid-cycle.
    initial forever begin
        @(negedge clock);
        if (ReadAddress1 != ra1_prev) begin
            ra1_log.push_back(ReadAddress1);
            ra2_log.push_back(ReadAddress2);
            ra1_prev = ReadAddress1;
        end
        if (done) begin
            done_cnt++;
            check("busy_at_done", busy, 1);
        end
        if (reset) hold_v = 1'b0;
        else begin
            if (edge_valid) valid_cnt++;
            if (hold_v) begin
                check("hold_valid", edge_valid, 1);
                check("hold_src", edge_src, hs);
                check("hold_dst", edge_dst, hd);
                check("hold_wgt", edge_weight, hw);
                check("hold_last", edge_last, hl);
            end
            hold_v = edge_valid && !edge_ready;
            hs = edge_src; hd = edge_dst; hw = edge_weight; hl = edge_last;
            if (edge_valid && edge_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) check("extra_edge", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("src", edge_src, e.s);
                    check("dst", edge_dst, e.d);
                    check("wgt", edge_weight, e.w);
                    check("last", edge_last, e.l);
                    if (e.w == 16'h8000) check("wgt_min", $signed(edge_weight), -32768);
                end
            end
        end
    end

    // Expected edge list straight from the packing rule: edge i lives in word base+i/2, half i%2.
    task automatic build_exp(input logic [12:0] base, input int cnt);
        exp_t         x;
        logic [127:0] w;
        logic [63:0]  r;
        exp_q.delete();
        for (int i = 0; i < cnt; i++) begin
            w   = mem[13'(int'(base) + i / 2)];
            r   = (i % 2 == 1) ? w[127:64] : w[63:0];
            x.s = r[63:51];
            x.d = r[50:38];
            x.w = r[37:22];
            x.l = (i == cnt - 1);
            exp_q.push_back(x);
        end
    endtask

    // Called just after a rising edge; launches the job immediately.
    task automatic run_job(input logic [12:0] base, input int cnt, input int md, input int stl);
        int c;
        build_exp(base, cnt);
        ra1_log.delete();
        ra2_log.delete();
        done_cnt = 0;
        valid_cnt = 0;
        start = 1'b1;
        base_addr = base;
        edge_count = 14'(cnt);
        edge_ready = rdy(0, md, stl);
        @(posedge clock); #1;
        start = 1'b0;
        if (cnt == 0) check("done_next_cycle", done, 1);
        else check("busy_after_start", busy, 1);
        c = 1;
        while (c < 3000 && done_cnt == 0) begin
            edge_ready = rdy(c, md, stl);
            @(posedge clock); #1;
            c++;
        end
        check("job_finished", done_cnt != 0, 1);
        edge_ready = 1'b1;
        repeat (4) begin @(posedge clock); #1; end
        check("done_once", done_cnt, 1);
        check("edges_left", exp_q.size(), 0);
        check("idle_after", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        repeat (3) @(posedge clock);
        #1;
        check("rst_valid", edge_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ra1", ReadAddress1, 0);
        check("rst_src", edge_src, 0);
        reset = 1'b0;
        // Zero-edge job.
        run_job(13'h20, 0, 0, 0);
        check("zero_no_edges", valid_cnt, 0);
        check("zero_no_reads", ra1_log.size(), 0);
        // Odd count, full throughput.
        run_job(13'h10, 5, 0, 0);
        check("odd_issues", ra1_log.size(), 2);
        if (ra1_log.size() == 2) begin
            check("odd_ra1_0", ra1_log[0], 13'h10);
            check("odd_ra2_0", ra2_log[0], 13'h11);
            check("odd_ra1_1", ra1_log[1], 13'h12);
        end
        // Back-pressure for 10 cycles.
        run_job(13'h100, 4, 2, 10);
        // Address wrap.
        run_job(13'h1FFF, 4, 0, 0);
        check("wrap_issues", ra1_log.size(), 1);
        if (ra1_log.size() == 1) begin
            check("wrap_ra1", ra1_log[0], 13'h1FFF);
            check("wrap_ra2", ra2_log[0], 13'h0000);
        end
        // Abort mid-job with reset after the 3rd edge.
        build_exp(13'h0300, 8);
        done_cnt = 0;
        xfer_cnt = 0;
        start = 1'b1; base_addr = 13'h0300; edge_count = 14'd8; edge_ready = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && xfer_cnt < 3; c++) @(posedge clock);
        check("abort_reached_3", xfer_cnt >= 3, 1);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        check("abort_valid", edge_valid, 0);
        check("abort_last", edge_last, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_ra1", ReadAddress1, 0);
        check("abort_ra2", ReadAddress2, 0);
        check("abort_src", edge_src, 0);
        check("abort_dst", edge_dst, 0);
        check("abort_wgt", edge_weight, 0);
        @(posedge clock); #1;
        check("abort_no_done", done_cnt, 0);
        reset = 1'b0;
        run_job(13'h0400, 2, 0, 0);
        // Long job, random ready, most-negative weight planted on edge 7.
        begin
            logic [127:0] w;
            w = mem[13'h0A03];
            w[101:86] = 16'h8000;
            mem[13'h0A03] = w;
        end
        run_job(13'h0A00, 200, 1, 0);
        for (int k = 0; k < 3; k++) run_job(13'($urandom), $urandom_range(1, 40), 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
